// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared types and default timing for the traffic light controller
package tlc_pkg;

  localparam int NUM_SIDES = 4;
  localparam int DEFAULT_GREEN_CYCLES = 20;
  localparam int DEFAULT_ORANGE_CYCLES = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    ORANGE = 2'd2
  } phase_t;

  typedef logic [1:0] side_t;

endpackage

// File: rtl/traffic_light_controller_if.sv
// rtl/traffic_light_controller_if.sv - sensor and lamp bundle between junction and controller
interface traffic_light_controller_if;
  import tlc_pkg::*;

  logic [NUM_SIDES-1:0] t;
  logic [NUM_SIDES-1:0] R;
  logic [NUM_SIDES-1:0] G;
  logic [NUM_SIDES-1:0] O;

  modport master (output t, input R, input G, input O);
  modport slave  (input t, output R, output G, output O);

endinterface

// File: rtl/traffic_light_controller_rr_pick.sv
// rtl/traffic_light_controller_rr_pick.sv - round-robin side selection after a base side
module rr_pick
  import tlc_pkg::*;
(
  input  logic [NUM_SIDES-1:0] req,
  input  side_t                base,
  output side_t                pick,
  output logic                 pick_valid
);

  // Scan base+3 down to base+1 so the nearest following side wins; fall back to base itself
  always_comb begin
    pick       = base;
    pick_valid = 1'b0;
    for (int k = 3; k >= 1; k--) begin
      if (req[base + 2'(k)]) begin
        pick       = base + 2'(k);
        pick_valid = 1'b1;
      end
    end
    if (!pick_valid && req[base]) begin
      pick       = base;
      pick_valid = 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_controller.sv
// rtl/traffic_light_controller.sv - four-way junction phase FSM, timer and lamp decode
module traffic_light_controller
  import tlc_pkg::*;
#(
  parameter int GREEN_CYCLES  = DEFAULT_GREEN_CYCLES,
  parameter int ORANGE_CYCLES = DEFAULT_ORANGE_CYCLES
) (
  input  logic                      clkdiv,
  input  logic                      rst_n,
  traffic_light_controller_if.slave bus
);

  localparam logic [7:0] GREEN_LAST  = 8'(GREEN_CYCLES - 1);
  localparam logic [7:0] ORANGE_LAST = 8'(ORANGE_CYCLES - 1);

  phase_t     phase_q, phase_d;
  side_t      side_q, side_d;
  side_t      next_q, next_d;
  logic       next_valid_q, next_valid_d;
  logic [7:0] count_q, count_d;

  side_t      rr_base;
  side_t      rr_side;
  logic       rr_valid;
  logic [3:0] side_onehot;

  // From IDLE the search must begin at side 0, hence base 3
  assign rr_base = (phase_q == IDLE) ? 2'd3 : side_q;

  rr_pick u_rr_pick (
    .req        (bus.t),
    .base       (rr_base),
    .pick       (rr_side),
    .pick_valid (rr_valid)
  );

  // Register all controller state; reset wins over every phase
  always_ff @(posedge clkdiv) begin
    if (!rst_n) begin
      phase_q      <= IDLE;
      side_q       <= 2'd0;
      next_q       <= 2'd0;
      next_valid_q <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      phase_q      <= phase_d;
      side_q       <= side_d;
      next_q       <= next_d;
      next_valid_q <= next_valid_d;
      count_q      <= count_d;
    end
  end

  // Phase transitions; sensors only matter at phase-end edges or when idle
  always_comb begin
    phase_d      = phase_q;
    side_d       = side_q;
    next_d       = next_q;
    next_valid_d = next_valid_q;
    count_d      = count_q;
    case (phase_q)
      IDLE: begin
        if (rr_valid) begin
          side_d  = rr_side;
          phase_d = GREEN;
          count_d = 8'd0;
        end
      end
      GREEN: begin
        count_d = count_q + 8'd1;
        if (count_q == GREEN_LAST) begin
          count_d = 8'd0;
          if (rr_valid && rr_side == side_q) begin
            phase_d = GREEN;
          end else begin
            phase_d      = ORANGE;
            next_d       = rr_side;
            next_valid_d = rr_valid;
          end
        end
      end
      ORANGE: begin
        count_d = count_q + 8'd1;
        if (count_q == ORANGE_LAST) begin
          count_d = 8'd0;
          if (next_valid_q) begin
            side_d       = next_q;
            phase_d      = GREEN;
            next_valid_d = 1'b0;
          end else begin
            phase_d = IDLE;
          end
        end
      end
      default: begin
        phase_d = IDLE;
        count_d = 8'd0;
      end
    endcase
  end

  assign side_onehot = 4'd1 << side_q;

  // Moore lamp decode: exactly one lamp per approach
  always_comb begin
    bus.G = 4'd0;
    bus.O = 4'd0;
    if (phase_q == GREEN)  bus.G = side_onehot;
    if (phase_q == ORANGE) bus.O = side_onehot;
    bus.R = ~(bus.G | bus.O);
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb/tb_traffic_light_controller.sv - directed scoreboard bench for traffic_light_controller
module tb_traffic_light_controller;

  localparam int GC = 20;
  localparam int OC = 5;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  traffic_light_controller_if tif ();

  traffic_light_controller #(
    .GREEN_CYCLES  (GC),
    .ORANGE_CYCLES (OC)
  ) dut (
    .clkdiv (clk),
    .rst_n  (rst_n),
    .bus    (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: phase 0 idle, 1 green, 2 orange; m_left = cycles of the phase still to show
  int         m_phase;
  int         m_side;
  int         m_next;
  int         m_left;
  logic [3:0] m_r;
  logic [3:0] m_g;
  logic [3:0] m_o;
  logic [11:0] exp_q[$];

  function automatic int rr(input int s, input logic [3:0] tv);
    for (int k = 1; k <= 3; k++) begin
      if (tv[(s + k) % 4]) return (s + k) % 4;
    end
    if (tv[s]) return s;
    return -1;
  endfunction

  task automatic model_edge(input logic [3:0] tv, input logic rv);
    int p;
    if (!rv) begin
      m_phase = 0; m_side = 0; m_next = -1; m_left = 0;
    end else begin
      case (m_phase)
        0: begin
          if (tv != 4'd0) begin
            m_side = rr(3, tv); m_phase = 1; m_left = GC;
          end
        end
        1: begin
          if (m_left > 1) m_left--;
          else begin
            p = rr(m_side, tv);
            if (p == m_side) m_left = GC;
            else begin
              m_next = p; m_phase = 2; m_left = OC;
            end
          end
        end
        default: begin
          if (m_left > 1) m_left--;
          else if (m_next >= 0) begin
            m_side = m_next; m_next = -1; m_phase = 1; m_left = GC;
          end else m_phase = 0;
        end
      endcase
    end
    m_g = (m_phase == 1) ? (4'd1 << m_side) : 4'd0;
    m_o = (m_phase == 2) ? (4'd1 << m_side) : 4'd0;
    m_r = ~(m_g | m_o);
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] tv, input logic rv);
    logic [11:0] e;
    @(negedge clk);
    tif.t = tv;
    rst_n = rv;
    model_edge(tv, rv);
    exp_q.push_back({m_r, m_g, m_o});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("scoreboard_RGO", {tif.R, tif.G, tif.O}, e);
    check("inv_R_is_not_GO", {8'd0, tif.R}, {8'd0, ~(tif.G | tif.O)});
    check("inv_G_and_O", {8'd0, tif.G & tif.O}, 12'd0);
    check("inv_onehot", {11'd0, $countones(tif.G | tif.O) <= 1}, 12'd1);
  endtask

  task automatic step_until_o(input logic [3:0] tv, input logic [3:0] exp_o, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * GC + 5; i++) begin
      step(tv, 1'b1);
      if (tif.O === exp_o) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, {11'd0, found}, 12'd1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    tif.t = 4'd0;

    // 1: reset with demand present, then green one cycle after release
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    check("reset_lamps", {tif.R, tif.G, tif.O}, 12'hF00);
    step(4'b0100, 1'b1);
    check("first_green", {tif.R, tif.G, tif.O}, 12'hB40);

    // 2: sole demand keeps extending green
    for (int i = 0; i < 100; i++) begin
      step(4'b0100, 1'b1);
      check("sole_green", {8'd0, tif.G}, 12'h004);
      check("sole_no_orange", {8'd0, tif.O}, 12'h000);
    end

    // 3: handover side 2 -> side 1
    step_until_o(4'b0010, 4'b0100, "handover_orange_seen");
    for (int i = 0; i < OC - 1; i++) begin
      step(4'b0010, 1'b1);
      check("handover_orange", {8'd0, tif.O}, 12'h004);
    end
    step(4'b0010, 1'b1);
    check("handover_green", {tif.R, tif.G, tif.O}, 12'hD20);

    // 4: round robin 1 -> 2, then 2 -> 3, then 3 wraps to 0
    step_until_o(4'b0110, 4'b0010, "rr1_orange_seen");
    for (int i = 0; i < OC - 1; i++) step(4'b0110, 1'b1);
    step(4'b0110, 1'b1);
    check("rr_1_to_2", {8'd0, tif.G}, 12'h004);
    step_until_o(4'b1000, 4'b0100, "rr2_orange_seen");
    for (int i = 0; i < OC - 1; i++) step(4'b1000, 1'b1);
    step(4'b1000, 1'b1);
    check("rr_2_to_3", {8'd0, tif.G}, 12'h008);
    step_until_o(4'b1001, 4'b1000, "rr3_orange_seen");
    for (int i = 0; i < OC - 1; i++) step(4'b1001, 1'b1);
    step(4'b1001, 1'b1);
    check("rr_wrap_to_0", {tif.R, tif.G, tif.O}, 12'hE10);

    // 5: demand drops for a fresh green: full green, full orange, then idle
    for (int i = 0; i < GC - 1; i++) begin
      step(4'b0000, 1'b1);
      check("drop_green_full", {8'd0, tif.G}, 12'h001);
    end
    for (int i = 0; i < OC; i++) begin
      step(4'b0000, 1'b1);
      check("drop_orange", {8'd0, tif.O}, 12'h001);
    end
    step(4'b0000, 1'b1);
    check("drop_idle", {tif.R, tif.G, tif.O}, 12'hF00);

    // 6: reset in the middle of orange
    step(4'b0001, 1'b1);
    check("idle_to_green0", {8'd0, tif.G}, 12'h001);
    step_until_o(4'b0011, 4'b0001, "mid_orange_seen");
    step(4'b0011, 1'b0);
    check("mid_orange_reset", {tif.R, tif.G, tif.O}, 12'hF00);
    step(4'b0000, 1'b1);
    check("post_reset_idle", {tif.R, tif.G, tif.O}, 12'hF00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
